mux3_arbiter: RTL
=================

Name: mux3_arbiter

Overview:
- Round-robin arbiter and sequencer for a shared 3-to-1 mux.
- Three requesters compete for the mux. The block grants one requester at a time and drives the mux 2-bit select to match.
- A grant is bounded by a configurable hold quantum, so no requester can starve the other two.
- Sits directly in front of the 3:1 mux in the datapath. sel connects straight to the mux select; grant returns to the requesters.

Parameters:
- HOLD_MAX, 4, maximum consecutive cycles one requester keeps the grant while another request is pending. Legal range 1..255.
- CNT_W, 8, width of the internal hold counter. Must satisfy 2^CNT_W > HOLD_MAX.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  reset; asynchronous and active-high.
- req  input  3  request per requester; bit i is requester i, the mux input a/b/c for i = 0/1/2.
- grant  output  3  one-hot grant, registered.
- sel  output  2  mux select (0 = a, 1 = b, 2 = c), registered. The value 3 is never driven.
- valid  output  1  high when any grant bit is set.
- expire  output  1  one-cycle pulse: the previous grant was preempted by quantum expiry.

Behaviour:
- Reset (asynchronous, active-high), applied immediately, including mid-grant:
  - grant = 000, sel = 0, valid = 0, expire = 0.
  - state = IDLE, hold counter cnt = 0, priority pointer ptr = 0.
- Priority search order from pointer p: p, p+1, p+2, all mod 3.
- All outputs are registered. A request sampled at edge N is reflected in grant/sel after edge N. Latency is 1 cycle.

State machine, IDLE:
- If req == 000: stay in IDLE, grant = 000.
- Otherwise: grant the first set req bit in search order from ptr, set cnt = 1, go to GRANT.

State machine, GRANT (holder h), evaluated each edge:
- Release, when req[h] == 0:
  - ptr = (h+1) mod 3.
  - If other requests are set, grant the first one in search order from ptr on the next cycle with no idle gap, and set cnt = 1.
  - Otherwise go to IDLE with grant = 000.
- Preempt, when cnt == HOLD_MAX and any req bit other than h is set:
  - ptr = (h+1) mod 3.
  - Grant the first requesting index other than h in search order from ptr, and set cnt = 1.
  - Assert expire for exactly the first cycle of the new grant.
- Hold, otherwise:
  - Keep the grant on h.
  - cnt increments and saturates at HOLD_MAX. With no contention, the grant persists indefinitely.

Output rules:
- sel equals the binary index of the granted requester.
- In IDLE, sel keeps its last granted value so the mux output does not glitch. After reset it is 0.
- grant is always one-hot or zero; two bits are never set together.
- valid = |grant.

Boundary conditions:
- Requests that change in the same cycle as a release or preempt: the values sampled at that edge are used.
- HOLD_MAX = 1: the grant rotates every cycle under contention.
- A requester that drops and re-raises its request after release waits its round-robin turn.

Test Plan:
- Assert rst while grant = 010 → grant = 000, sel = 0, valid = 0 immediately, without waiting for a clk edge. After release, req = 111 grants 001 first, since ptr = 0.
- HOLD_MAX = 4, req = 010 held for 10 cycles → grant = 010 and sel = 1 from cycle 1 through cycle 10. expire never pulses. cnt stays saturated at 4.
- HOLD_MAX = 4, req = 111 held → grant sequence 001×4, 010×4, 100×4, 001×4, … with sel following 0/1/2. No gap cycles. expire pulses on the first cycle of each new grant.
- Requester 0 holds the grant for 2 cycles, then req goes from 101 to 100 → next cycle grant = 100, sel = 2, expire = 0. When req then drops to 000 → next cycle grant = 000, valid = 0, sel stays 2.
- From reset, req = 110 → grant = 010 (index 0 is skipped). After a preempt at HOLD_MAX, grant moves to 100.
- HOLD_MAX = 1, req = 101 held → grant alternates 001, 100, 001, 100, … with expire high on every cycle after the first grant.

Source files
------------

// File: rtl/mux3_arbiter.sv
// Round-robin arbiter that owns the select of a shared 3:1 mux.
// One requester holds the mux at a time. The grant is bounded by a hold
// quantum whenever another requester is waiting, so no requester starves.
// grant, sel, valid and expire are all registered.
module mux3_arbiter #(
  parameter int HOLD_MAX = 4,
  parameter int CNT_W    = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] req,
  output logic [2:0] grant,
  output logic [1:0] sel,
  output logic       valid,
  output logic       expire
);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_e;

  localparam logic [CNT_W-1:0] HOLD_C  = CNT_W'(HOLD_MAX);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  // Advance an index by one, wrapping modulo 3.
  function automatic logic [1:0] inc3(input logic [1:0] p);
    logic [1:0] r;
    case (p)
      2'd0:    r = 2'd1;
      2'd1:    r = 2'd2;
      default: r = 2'd0;
    endcase
    return r;
  endfunction

  // Convert a requester index to its one-hot grant vector.
  function automatic logic [2:0] onehot(input logic [1:0] idx);
    logic [2:0] r;
    case (idx)
      2'd0:    r = 3'b001;
      2'd1:    r = 3'b010;
      2'd2:    r = 3'b100;
      default: r = 3'b000;
    endcase
    return r;
  endfunction

  // First set bit of r, searching p, p+1, p+2 (mod 3).
  // The result is {found, index}.
  function automatic logic [2:0] rr_pick(input logic [2:0] r, input logic [1:0] p);
    logic [2:0] res;
    logic [1:0] i;
    res = 3'b000;
    i   = p;
    for (int k = 0; k < 3; k++) begin
      if (!res[2] && ((r & onehot(i)) != 3'b000)) begin
        res = {1'b1, i};
      end else begin
        res = res;
      end
      i = inc3(i);
    end
    return res;
  endfunction

  state_e           state_q, state_d;
  logic [2:0]       grant_q, grant_d;
  logic [1:0]       sel_q, sel_d;
  logic             valid_q, valid_d;
  logic             expire_q, expire_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       ptr_q, ptr_d;

  logic [2:0]       pick_s;
  logic [2:0]       others_s;
  logic [1:0]       nptr_s;
  logic             held_s;

  // Next-state logic: choose the next holder, hold counter and pointer.
  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    sel_d    = sel_q;
    cnt_d    = cnt_q;
    ptr_d    = ptr_q;
    expire_d = 1'b0;
    pick_s   = 3'b000;
    others_s = 3'b000;
    nptr_s   = inc3(sel_q);
    held_s   = ((req & onehot(sel_q)) != 3'b000);

    case (state_q)
      ST_IDLE: begin
        pick_s = rr_pick(req, ptr_q);
        if (pick_s[2]) begin
          state_d = ST_GRANT;
          grant_d = onehot(pick_s[1:0]);
          sel_d   = pick_s[1:0];
          cnt_d   = CNT_ONE;
        end else begin
          grant_d = 3'b000;
        end
      end
      ST_GRANT: begin
        // Candidates other than the holder, searched from the slot after it.
        others_s = req & ~onehot(sel_q);
        pick_s   = rr_pick(others_s, nptr_s);
        if (!held_s) begin
          // Holder released: hand over immediately, or go idle.
          ptr_d = nptr_s;
          if (pick_s[2]) begin
            grant_d = onehot(pick_s[1:0]);
            sel_d   = pick_s[1:0];
            cnt_d   = CNT_ONE;
          end else begin
            state_d = ST_IDLE;
            grant_d = 3'b000;
          end
        end else if ((cnt_q == HOLD_C) && pick_s[2]) begin
          // Quantum used up while another requester waits: preempt.
          ptr_d    = nptr_s;
          grant_d  = onehot(pick_s[1:0]);
          sel_d    = pick_s[1:0];
          cnt_d    = CNT_ONE;
          expire_d = 1'b1;
        end else begin
          // Keep the grant. The counter saturates at the quantum.
          if (cnt_q < HOLD_C) begin
            cnt_d = cnt_q + CNT_ONE;
          end else begin
            cnt_d = cnt_q;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = 3'b000;
      end
    endcase

    valid_d = (grant_d != 3'b000);
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      grant_q  <= 3'b000;
      sel_q    <= 2'd0;
      valid_q  <= 1'b0;
      expire_q <= 1'b0;
      cnt_q    <= '0;
      ptr_q    <= 2'd0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      sel_q    <= sel_d;
      valid_q  <= valid_d;
      expire_q <= expire_d;
      cnt_q    <= cnt_d;
      ptr_q    <= ptr_d;
    end
  end

  assign grant  = grant_q;
  assign sel    = sel_q;
  assign valid  = valid_q;
  assign expire = expire_q;

endmodule
